mbist_host_ctrl: RTL and testbench

- Initiator side of the MBIST scan/run interface. Drives bist_en/bist_shift/bist_load/bist_sdi/bist_run into an MBIST instance and collects bist_done/bist_error/bist_correct/bist_error_cnt/bist_sdo.
- A single start pulse performs the full sequence: serial config shift-in, load pulse, run until done, status capture.
- Sits between the chip register block and one MBIST instance.

---
 rtl/mbist_host_ctrl_if.sv | 23 ++
 rtl/mbist_host_ctrl.sv | 138 +++++++++++++
 tb/tb_mbist_host_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_host_ctrl_if.sv
// MBIST scan/run bus between the host sequencer (master) and one MBIST instance (slave).
interface mbist_host_ctrl_if;
  logic       bist_en;
  logic       bist_run;
  logic       bist_shift;
  logic       bist_load;
  logic       bist_sdi;
  logic       bist_sdo;
  logic       bist_done;
  logic       bist_error;
  logic       bist_correct;
  logic [3:0] bist_error_cnt;

  modport master (
    output bist_en, bist_run, bist_shift, bist_load, bist_sdi,
    input  bist_sdo, bist_done, bist_error, bist_correct, bist_error_cnt
  );

  modport slave (
    input  bist_en, bist_run, bist_shift, bist_load, bist_sdi,
    output bist_sdo, bist_done, bist_error, bist_correct, bist_error_cnt
  );
endinterface

// File: rtl/mbist_host_ctrl.sv
// MBIST host sequencer: scan config in (LSB first), load strobe, run to bist_done, capture status.
// Latency: cfg_start to cfg_done pulse is SCAN_WD + 4 + run cycles (37 for SCAN_WD=32, immediate done).
// No queueing: cfg_start is dropped while cfg_busy; MBIST_HOST_TIMEOUT_EN adds the run-phase watchdog.
module mbist_host_ctrl #(
  parameter int unsigned SCAN_WD     = 32,
  parameter int unsigned TIMEOUT_WD  = 16,
  parameter int unsigned TIMEOUT_CYC = 16'hFFFF
) (
  input  logic               bist_clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic [SCAN_WD-1:0] cfg_data,
  output logic               cfg_busy,
  output logic               cfg_done,
  output logic               sts_error,
  output logic               sts_correct,
  output logic [3:0]         sts_error_cnt,
  output logic               sts_timeout,
  output logic [SCAN_WD-1:0] sts_rdata,
  mbist_host_ctrl_if.master  mb
);
  localparam int CNT_WD = (SCAN_WD > 1) ? $clog2(SCAN_WD) : 1;
  localparam logic [CNT_WD-1:0] LAST_BIT = CNT_WD'(SCAN_WD - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, LOAD, RUN, CAPT, FIN} state_t;

  state_t             state;
  logic [SCAN_WD-1:0] sreg;
  logic [SCAN_WD-1:0] sreg_nxt;
  logic [CNT_WD-1:0]  bit_cnt;
  logic               en_q;
  logic               run_q;
  logic               shift_q;
  logic               load_q;
  logic               wd_expired;

  // Old chain contents stream in at the MSB while the new image leaves from the LSB.
  assign sreg_nxt = {mb.bist_sdo, sreg[SCAN_WD-1:1]};

  assign mb.bist_en    = en_q;
  assign mb.bist_run   = run_q;
  assign mb.bist_shift = shift_q;
  assign mb.bist_load  = load_q;
  assign mb.bist_sdi   = shift_q & sreg[0];

`ifdef MBIST_HOST_TIMEOUT_EN
  localparam logic [TIMEOUT_WD-1:0] WD_LAST = TIMEOUT_WD'(TIMEOUT_CYC - 1);
  logic [TIMEOUT_WD-1:0] wd_cnt;
  logic                  timeout_q;
  assign wd_expired  = (wd_cnt == WD_LAST);
  assign sts_timeout = timeout_q;
`else
  assign wd_expired  = 1'b0;
  assign sts_timeout = 1'b0;
`endif

  always_ff @(posedge bist_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sreg          <= '0;
      bit_cnt       <= '0;
      cfg_busy      <= 1'b0;
      cfg_done      <= 1'b0;
      sts_error     <= 1'b0;
      sts_correct   <= 1'b0;
      sts_error_cnt <= '0;
      sts_rdata     <= '0;
      en_q          <= 1'b0;
      run_q         <= 1'b0;
      shift_q       <= 1'b0;
      load_q        <= 1'b0;
`ifdef MBIST_HOST_TIMEOUT_EN
      wd_cnt        <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      cfg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            sreg     <= cfg_data;
            bit_cnt  <= '0;
            cfg_busy <= 1'b1;
            en_q     <= 1'b1;
            shift_q  <= 1'b1;
            state    <= SHIFT;
`ifdef MBIST_HOST_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          sreg    <= sreg_nxt;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            sts_rdata <= sreg_nxt;
            shift_q   <= 1'b0;
            load_q    <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          load_q <= 1'b0;
          run_q  <= 1'b1;
          state  <= RUN;
`ifdef MBIST_HOST_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        RUN: begin
          // bist_done takes priority over a watchdog expiry in the same cycle.
          if (mb.bist_done || wd_expired) begin
            run_q <= 1'b0;
            state <= CAPT;
`ifdef MBIST_HOST_TIMEOUT_EN
            timeout_q <= ~mb.bist_done;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        CAPT: begin
          sts_error     <= mb.bist_error;
          sts_correct   <= mb.bist_correct;
          sts_error_cnt <= mb.bist_error_cnt;
          en_q          <= 1'b0;
          cfg_done      <= 1'b1;
          state         <= FIN;
        end
        FIN: begin
          cfg_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mbist_host_ctrl.sv
// Bench for mbist_host_ctrl: behavioural scan chain / MBIST model, expected-result queue, cfg_done monitor.
module tb_mbist_host_ctrl;
  localparam int unsigned SCAN_WD = 32;
  localparam int unsigned TO_CYC  = 16;
  localparam int          NEVER   = 100000;
`ifdef MBIST_HOST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] img;
    logic        err;
    logic        corr;
    logic [3:0]  cnt;
    logic        to;
    int          run_len;
    int          lat;
    int          start_cyc;
  } exp_t;

  logic               bist_clk;
  logic               rst_n;
  logic               cfg_start;
  logic [SCAN_WD-1:0] cfg_data;
  logic               cfg_busy;
  logic               cfg_done;
  logic               sts_error;
  logic               sts_correct;
  logic [3:0]         sts_error_cnt;
  logic               sts_timeout;
  logic [SCAN_WD-1:0] sts_rdata;

  mbist_host_ctrl_if mb ();

  mbist_host_ctrl #(
    .SCAN_WD     (SCAN_WD),
    .TIMEOUT_WD  (16),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .bist_clk      (bist_clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_data      (cfg_data),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .sts_error     (sts_error),
    .sts_correct   (sts_correct),
    .sts_error_cnt (sts_error_cnt),
    .sts_timeout   (sts_timeout),
    .sts_rdata     (sts_rdata),
    .mb            (mb.master)
  );

  initial bist_clk = 1'b0;
  always #5 bist_clk = ~bist_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge bist_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- MBIST + scan chain model ----------------
  logic [SCAN_WD-1:0] chain  = '0;
  int                 k_delay = 0;
  logic               k_err   = 1'b0;
  logic               k_corr  = 1'b0;
  logic [3:0]         k_cnt   = '0;
  int                 run_cnt = 0;
  logic               m_done  = 1'b0;
  logic               m_err   = 1'b0;
  logic               m_corr  = 1'b0;
  logic [3:0]         m_cnt   = '0;

  assign mb.bist_sdo       = chain[0];
  assign mb.bist_done      = m_done;
  assign mb.bist_error     = m_err;
  assign mb.bist_correct   = m_corr;
  assign mb.bist_error_cnt = m_cnt;

  // Status/done persist after a run until the next load, so done is also seen during IDLE and SHIFT.
  always @(posedge bist_clk) begin
    if (mb.bist_shift) chain <= {mb.bist_sdi, chain[SCAN_WD-1:1]};
    if (mb.bist_load) begin
      run_cnt <= 0;
      m_done  <= (k_delay == 0);
      m_err   <= (k_delay == 0) ? k_err  : 1'b0;
      m_corr  <= (k_delay == 0) ? k_corr : 1'b0;
      m_cnt   <= (k_delay == 0) ? k_cnt  : 4'd0;
    end else if (mb.bist_run) begin
      if (run_cnt == k_delay - 1) begin
        m_done <= 1'b1;
        m_err  <= k_err;
        m_corr <= k_corr;
        m_cnt  <= k_cnt;
      end
      run_cnt <= run_cnt + 1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  exp_t exp_q[$];
  int   shift_n  = 0;
  int   run_n    = 0;
  bit   excl_bad = 1'b0;
  bit   chk_idle = 1'b0;

  always @(negedge bist_clk) begin
    exp_t e;
    if (!rst_n) begin
      shift_n  = 0;
      run_n    = 0;
      excl_bad = 1'b0;
      chk_idle = 1'b0;
    end else begin
      if (mb.bist_shift) shift_n++;
      if (mb.bist_run)   run_n++;
      if (int'(mb.bist_shift) + int'(mb.bist_load) + int'(mb.bist_run) > 1) excl_bad = 1'b1;
      if (chk_idle) begin
        check("busy_after_done", {31'd0, cfg_busy}, 32'd0);
        check("done_one_cycle", {31'd0, cfg_done}, 32'd0);
        chk_idle = 1'b0;
      end
      if (cfg_done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: cfg_done with no sequence outstanding (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("rdata",      sts_rdata, e.rdata);
          check("chain_img",  chain, e.img);
          check("sts_error",  {31'd0, sts_error}, {31'd0, e.err});
          check("sts_correct",{31'd0, sts_correct}, {31'd0, e.corr});
          check("sts_cnt",    {28'd0, sts_error_cnt}, {28'd0, e.cnt});
          check("sts_timeout",{31'd0, sts_timeout}, {31'd0, e.to});
          check("shift_cycles", shift_n, SCAN_WD);
          check("run_cycles", run_n, e.run_len);
          check("latency",    cyc - e.start_cyc + 1, e.lat);
          check("exclusive",  {31'd0, excl_bad}, 32'd0);
        end
        shift_n  = 0;
        run_n    = 0;
        excl_bad = 1'b0;
        chk_idle = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] ref_img = '0;

  function automatic logic [31:0] outs_vec();
    return {19'd0, cfg_busy, cfg_done, sts_error, sts_correct, sts_error_cnt, sts_timeout,
            mb.bist_en, mb.bist_run, mb.bist_shift, mb.bist_load, mb.bist_sdi};
  endfunction

  task automatic wait_idle();
    int k = 0;
    while ((cfg_busy || cfg_done) && k < 3000) begin
      @(negedge bist_clk);
      k++;
    end
    if (k >= 3000) bound_fail("wait_idle");
  endtask

  task automatic run_seq(input logic [31:0] data, input int delay, input logic err,
                         input logic corr, input logic [3:0] cnt, input bit poke);
    exp_t e;
    int   rl;
    bit   cap;
    wait_idle();
    k_delay = delay;
    k_err   = err;
    k_corr  = corr;
    k_cnt   = cnt;
    rl      = delay + 1;
    e.to    = 1'b0;
    if (TO_EN && rl > int'(TO_CYC)) begin
      rl   = TO_CYC;
      e.to = 1'b1;
    end
    cap        = (delay <= rl);
    e.run_len  = rl;
    e.err      = cap ? err : 1'b0;
    e.corr     = cap ? corr : 1'b0;
    e.cnt      = cap ? cnt : 4'd0;
    e.rdata    = ref_img;
    e.img      = data;
    e.lat      = 1 + SCAN_WD + 1 + rl + 1 + 1;
    e.start_cyc = cyc;
    ref_img    = data;
    exp_q.push_back(e);
    cfg_data  = data;
    cfg_start = 1'b1;
    @(negedge bist_clk);
    cfg_start = 1'b0;
    cfg_data  = $urandom;
    if (poke) begin
      repeat ($urandom_range(2, 30)) @(negedge bist_clk);
      cfg_start = 1'b1;
      cfg_data  = $urandom;
      @(negedge bist_clk);
      cfg_start = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int k;
    logic [31:0] d;
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    cfg_data  = '0;
    repeat (3) @(negedge bist_clk);
    check("reset_outs", outs_vec(), 32'd0);
    check("reset_rdata", sts_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge bist_clk);
    check("post_reset_outs", outs_vec(), 32'd0);

    // Readback from a zeroed chain, immediate done (minimum latency).
    run_seq(32'hA5C3_0F81, 0, 1'b0, 1'b0, 4'd0, 1'b0);
    // Pass run: done 100 cycles after bist_run rises; old image read back.
    run_seq(32'h1234_5678, 100, 1'b0, 1'b0, 4'd0, 1'b0);
    // Repair run with a start poked in while busy.
    run_seq($urandom, 7, 1'b1, 1'b1, 4'd3, 1'b1);
    wait_idle();
    repeat (5) @(negedge bist_clk);
    check("hold_error",   {31'd0, sts_error}, 32'd1);
    check("hold_correct", {31'd0, sts_correct}, 32'd1);
    check("hold_cnt",     {28'd0, sts_error_cnt}, 32'd3);

`ifdef MBIST_HOST_TIMEOUT_EN
    run_seq($urandom, NEVER, 1'b1, 1'b0, 4'd9, 1'b0);
    run_seq($urandom, TO_CYC - 1, 1'b1, 1'b0, 4'd5, 1'b0);
    run_seq($urandom, TO_CYC, 1'b0, 1'b1, 4'd2, 1'b0);
`endif

    // Reset mid-RUN: abandoned sequence leaves nothing outstanding.
    wait_idle();
    d = $urandom;
    k_delay   = NEVER;
    cfg_data  = d;
    cfg_start = 1'b1;
    @(negedge bist_clk);
    cfg_start = 1'b0;
    ref_img   = d;
    k = 0;
    while (!mb.bist_run && k < 200) begin
      @(negedge bist_clk);
      k++;
    end
    if (!mb.bist_run) bound_fail("wait_run");
    repeat (5) @(negedge bist_clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_outs", outs_vec(), 32'd0);
    check("midrun_reset_rdata", sts_rdata, 32'd0);
    repeat (2) @(negedge bist_clk);
    check("in_reset_outs", outs_vec(), 32'd0);
    rst_n = 1'b1;
    run_seq($urandom, 3, 1'b0, 1'b1, 4'd1, 1'b0);

    // Randomised sequences.
    for (int i = 0; i < 20; i++) begin
      run_seq($urandom, $urandom_range(0, 40), 1'($urandom), 1'($urandom),
              4'($urandom), 1'($urandom_range(0, 1)));
    end

    wait_idle();
    repeat (3) @(negedge bist_clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
